// File: rtl/timer_pkg.sv
// Shared constants for the memory-mapped interval timer: register offsets,
// TCON bit positions, window size and the default base address.
package timer_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned PRESC_W   = 16;
  localparam int unsigned WIN_WORDS = 6;
  localparam int unsigned WIN_BYTES = WIN_WORDS * 4;

  localparam logic [DATA_W-1:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

  // Byte offsets from the base address
  localparam logic [DATA_W-1:0] TH_OFF      = 32'h0000_0000;
  localparam logic [DATA_W-1:0] TL_OFF      = 32'h0000_0004;
  localparam logic [DATA_W-1:0] TCON_OFF    = 32'h0000_0008;
  localparam logic [DATA_W-1:0] RSVD_OFF    = 32'h0000_000C;
  localparam logic [DATA_W-1:0] SYSTICK_OFF = 32'h0000_0014;

  // TCON bit indices
  localparam int unsigned EN_BIT = 0;
  localparam int unsigned IE_BIT = 1;
  localparam int unsigned ST_BIT = 2;

  // Packed so that st/ie/en land on bits 2/1/0
  typedef struct packed {
    logic st;
    logic ie;
    logic en;
  } tcon_t;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: while en is high, counts 0..PRESCALE-1 and flags the last count
// as a one-cycle tick. Count is forced to 0 whenever en is low.
// Ports: clk, reset (sync, active-high), en (count enable), tick (comb).
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  logic [PRESC_W-1:0] count_q;
  logic [PRESC_W-1:0] count_d;

  // Tick on the terminal count; PRESCALE=1 keeps count at 0 so tick == en
  always_comb begin
    tick    = en && (count_q == PRESC_W'(PRESCALE - 1));
    count_d = count_q;
    if (!en) begin
      count_d = '0;
    end else if (tick) begin
      count_d = '0;
    end else begin
      count_d = count_q + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/timer_peripheral.sv
// Memory-mapped interval timer with reload and free-running SysTick.
// Ports: clk, reset (sync, active-high), MemRd/MemWr strobes, Addr (byte
// address, [1:0] ignored), WriteData, ReadData (combinational read data),
// IRQ (registered, level-sensitive interrupt request).
module timer_peripheral
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRd,
  input  logic              MemWr,
  input  logic [DATA_W-1:0] Addr,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              IRQ
);

  localparam logic [2:0] TH_W      = TH_OFF[4:2];
  localparam logic [2:0] TL_W      = TL_OFF[4:2];
  localparam logic [2:0] TCON_W    = TCON_OFF[4:2];
  localparam logic [2:0] SYSTICK_W = SYSTICK_OFF[4:2];

  logic [DATA_W-1:0] th_q, th_d;
  logic [DATA_W-1:0] tl_q, tl_d;
  tcon_t             tcon_q, tcon_d;
  logic [DATA_W-1:0] systick_q, systick_d;
  logic              irq_q, irq_d;

  logic [DATA_W-1:0] off_c;
  logic              hit_c;
  logic [2:0]        word_c;
  logic              tick_c;
  logic              ovf_c;
  logic [DATA_W-1:0] rdata_c;

  timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (tcon_q.en),
    .tick  (tick_c)
  );

  // Address decode: base is word-aligned, so the range check covers [1:0]
  always_comb begin
    off_c  = Addr - BASE_ADDR;
    hit_c  = off_c < DATA_W'(WIN_BYTES);
    word_c = off_c[4:2];
  end

  // Read mux; returns pre-write state when a write shares the cycle
  always_comb begin
    rdata_c = '0;
    if (MemRd && hit_c && !reset) begin
      case (word_c)
        TH_W:      rdata_c = th_q;
        TL_W:      rdata_c = tl_q;
        TCON_W:    rdata_c = DATA_W'(tcon_q);
        SYSTICK_W: rdata_c = systick_q;
        default:   rdata_c = '0;
      endcase
    end
  end

  assign ReadData = rdata_c;
  assign IRQ      = irq_q;

  // Counter update first, bus writes override; overflow-set ST survives a clear
  always_comb begin
    th_d      = th_q;
    tl_d      = tl_q;
    tcon_d    = tcon_q;
    systick_d = systick_q + DATA_W'(1);
    irq_d     = tcon_q.ie & tcon_q.st;
    ovf_c     = tick_c && (tl_q == '1);

    if (tick_c) begin
      tl_d = ovf_c ? th_q : tl_q + DATA_W'(1);
    end
    if (ovf_c && tcon_q.ie) begin
      tcon_d.st = 1'b1;
    end

    if (MemWr && hit_c) begin
      case (word_c)
        TH_W: th_d = WriteData;
        TL_W: tl_d = WriteData;
        TCON_W: begin
          tcon_d.en = WriteData[EN_BIT];
          tcon_d.ie = WriteData[IE_BIT];
          tcon_d.st = WriteData[ST_BIT] | (ovf_c & tcon_q.ie);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      th_q      <= '0;
      tl_q      <= '0;
      tcon_q    <= '0;
      systick_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      systick_q <= systick_d;
      irq_q     <= irq_d;
    end
  end

endmodule

// File: tb/tb_timer_peripheral.sv
// Bench for timer_peripheral: one instance with PRESCALE=1 and one with
// PRESCALE=4 share the bus. Inputs change on the falling edge; outputs are
// sampled 1 time unit later, ahead of the next rising edge.
module tb_timer_peripheral;
  import timer_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int K_RD1  = 0;
  localparam int K_IRQ1 = 1;
  localparam int K_RD4  = 2;
  localparam int K_IRQ4 = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemRd = 1'b0;
  logic        MemWr = 1'b0;
  logic [31:0] Addr = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] rd1, rd4;
  logic        irq1, irq4;

  always #5 clk = ~clk;

  timer_peripheral #(.BASE_ADDR(BASE), .PRESCALE(1)) u_dut1 (
    .clk(clk), .reset(reset), .MemRd(MemRd), .MemWr(MemWr),
    .Addr(Addr), .WriteData(WriteData), .ReadData(rd1), .IRQ(irq1)
  );

  timer_peripheral #(.BASE_ADDR(BASE), .PRESCALE(4)) u_dut4 (
    .clk(clk), .reset(reset), .MemRd(MemRd), .MemWr(MemWr),
    .Addr(Addr), .WriteData(WriteData), .ReadData(rd4), .IRQ(irq4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference SysTick: cleared by a reset edge, +1 on every other edge
  logic [31:0] systick_ref = '0;
  always @(posedge clk) begin
    if (reset) systick_ref <= '0;
    else       systick_ref <= systick_ref + 32'd1;
  end

  typedef struct {
    string       nm;
    int          kind;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] off;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_irq;
    string       nm;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t v(input logic rd, input logic wr, input logic [31:0] off,
                             input logic [31:0] wd, input logic [31:0] exp_rd,
                             input logic exp_irq, input string nm);
    vec_t r;
    r.rd = rd; r.wr = wr; r.off = off; r.wd = wd;
    r.exp_rd = exp_rd; r.exp_irq = exp_irq; r.nm = nm;
    return r;
  endfunction

  function automatic void push(input string nm, input int kind, input logic [31:0] val);
    exp_t e;
    e.nm = nm; e.kind = kind; e.val = val;
    sb_q.push_back(e);
  endfunction

  task automatic step(input logic rst, input logic rd, input logic wr,
                      input logic [31:0] off, input logic [31:0] wd);
    @(negedge clk);
    reset = rst; MemRd = rd; MemWr = wr; Addr = BASE + off; WriteData = wd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Pop every pending expectation and compare it with the live DUT output
  task automatic check();
    exp_t        e;
    logic [31:0] act;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.kind)
        K_RD1:   act = rd1;
        K_IRQ1:  act = 32'(irq1);
        K_RD4:   act = rd4;
        default: act = 32'(irq4);
      endcase
      n_checks++;
      if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.nm, act, e.val);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Stimulus table for the PRESCALE=1 instance, applied from a reset state
    tbl.push_back(v(0, 1, TH_OFF,   32'hFFFF_FFFC, 32'h0,         0, "wr_th"));
    tbl.push_back(v(0, 1, TL_OFF,   32'hFFFF_FFFC, 32'h0,         0, "wr_tl"));
    tbl.push_back(v(0, 1, TCON_OFF, 32'h3,         32'h0,         0, "wr_tcon3"));
    tbl.push_back(v(1, 0, TL_OFF,   32'h0, 32'hFFFF_FFFC, 0, "tl_fc"));
    tbl.push_back(v(1, 0, TL_OFF,   32'h0, 32'hFFFF_FFFD, 0, "tl_fd"));
    tbl.push_back(v(1, 0, TL_OFF,   32'h0, 32'hFFFF_FFFE, 0, "tl_fe"));
    tbl.push_back(v(1, 0, TL_OFF,   32'h0, 32'hFFFF_FFFF, 0, "tl_ff"));
    tbl.push_back(v(1, 0, TCON_OFF, 32'h0, 32'h7,         0, "st_set"));
    tbl.push_back(v(1, 0, TL_OFF,   32'h0, 32'hFFFF_FFFD, 1, "irq_rise"));
    tbl.push_back(v(0, 1, TCON_OFF, 32'h3, 32'h0,         1, "clr_st"));
    tbl.push_back(v(1, 0, TCON_OFF, 32'h0, 32'h3,         1, "st_cleared"));
    tbl.push_back(v(1, 0, TCON_OFF, 32'h0, 32'h7,         0, "irq_drop"));
    tbl.push_back(v(1, 0, TL_OFF,   32'h0, 32'hFFFF_FFFD, 1, "tl_fd2"));
    tbl.push_back(v(1, 0, TL_OFF,   32'h0, 32'hFFFF_FFFE, 1, "tl_fe2"));
    tbl.push_back(v(0, 1, TCON_OFF, 32'h3, 32'h0,         1, "clr_vs_ovf"));
    tbl.push_back(v(1, 0, TCON_OFF, 32'h0, 32'h7,         1, "st_kept"));
    tbl.push_back(v(1, 1, TL_OFF,   32'h100, 32'hFFFF_FFFD, 1, "rd_pre_wr"));
    tbl.push_back(v(1, 0, TL_OFF,   32'h0, 32'h100,       1, "wr_beats_tick"));
    tbl.push_back(v(0, 1, TCON_OFF, 32'h0, 32'h0,         1, "wr_tcon0"));
    tbl.push_back(v(1, 0, TL_OFF,   32'h0, 32'h102,       1, "last_tick"));
    tbl.push_back(v(1, 0, TCON_OFF, 32'h0, 32'h0,         0, "tcon0"));
    tbl.push_back(v(0, 1, 32'h40,   32'hFFFF_FFFF, 32'h0, 0, "wr_outside"));
    tbl.push_back(v(1, 0, 32'h40,   32'h0, 32'h0,         0, "rd_outside"));
    tbl.push_back(v(0, 1, RSVD_OFF, 32'hFFFF_FFFF, 32'h0, 0, "wr_rsvd"));
    tbl.push_back(v(1, 0, RSVD_OFF, 32'h0, 32'h0,         0, "rd_rsvd"));
    tbl.push_back(v(1, 0, 32'h10,   32'h0, 32'h0,         0, "rd_0x10"));
    tbl.push_back(v(1, 0, TH_OFF,   32'h0, 32'hFFFF_FFFC, 0, "th_intact"));
    tbl.push_back(v(1, 0, TL_OFF,   32'h0, 32'h102,       0, "tl_hold"));
    tbl.push_back(v(1, 0, 32'h6,    32'h0, 32'h102,       0, "tl_unaligned"));
    tbl.push_back(v(1, 0, TCON_OFF, 32'h0, 32'h0,         0, "tcon_intact"));
    tbl.push_back(v(0, 0, TH_OFF,   32'h0, 32'h0,         0, "no_rd"));
    tbl.push_back(v(0, 1, TH_OFF,   32'h55, 32'h0,        0, "wr_th55"));
    tbl.push_back(v(1, 0, TH_OFF,   32'h0, 32'h55,        0, "th55"));
    tbl.push_back(v(0, 1, TL_OFF,   32'hFFFF_FFFF, 32'h0, 0, "wr_tl_ff"));
    tbl.push_back(v(0, 1, TCON_OFF, 32'h1, 32'h0,         0, "wr_tcon1"));
    tbl.push_back(v(0, 1, TH_OFF,   32'h77, 32'h0,        0, "th_vs_reload"));
    tbl.push_back(v(1, 0, TL_OFF,   32'h0, 32'h55,        0, "reload_old_th"));
    tbl.push_back(v(1, 0, TH_OFF,   32'h0, 32'h77,        0, "th77"));
    tbl.push_back(v(1, 0, TCON_OFF, 32'h0, 32'h1,         0, "ie0_no_st"));
    tbl.push_back(v(0, 1, TCON_OFF, 32'h0, 32'h0,         0, "stop"));

    // Reset, then all registers read 0 while reset is held
    step(1, 0, 0, 32'h0, 32'h0);
    step(1, 0, 0, 32'h0, 32'h0);
    foreach (tbl[i]) begin end
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 0, 32'(i * 4), 32'h0);
      push("rst_rd1", K_RD1, 32'h0);
      push("rst_rd4", K_RD4, 32'h0);
      push("rst_irq1", K_IRQ1, 32'h0);
      check();
    end
    // After release: register reads then SYSTICK four cycles in
    step(0, 1, 0, TH_OFF, 32'h0);   push("post_th", K_RD1, 32'h0);   check();
    step(0, 1, 0, TL_OFF, 32'h0);   push("post_tl", K_RD1, 32'h0);   check();
    step(0, 1, 0, TCON_OFF, 32'h0); push("post_tcon", K_RD1, 32'h0); check();
    step(0, 1, 0, RSVD_OFF, 32'h0); push("post_rsvd", K_RD1, 32'h0); check();
    step(0, 1, 0, SYSTICK_OFF, 32'h0);
    push("systick4", K_RD1, 32'd4);
    push("systick4_p4", K_RD4, 32'd4);
    push("post_irq", K_IRQ1, 32'h0);
    check();

    // Table-driven sequence on the PRESCALE=1 instance
    step(1, 0, 0, 32'h0, 32'h0);
    foreach (tbl[i]) begin
      step(0, tbl[i].rd, tbl[i].wr, tbl[i].off, tbl[i].wd);
      push(tbl[i].nm, K_RD1, tbl[i].exp_rd);
      push({tbl[i].nm, "_irq"}, K_IRQ1, 32'(tbl[i].exp_irq));
      check();
    end

    // SYSTICK ignores writes
    step(0, 0, 1, SYSTICK_OFF, 32'h0);
    push("wr_systick", K_RD1, 32'h0);
    check();
    step(0, 1, 0, SYSTICK_OFF, 32'h0);
    push("systick_ro", K_RD1, systick_ref);
    check();

    // PRESCALE=4: 12 cycles of counting gives 3 ticks
    step(1, 0, 0, 32'h0, 32'h0);
    step(0, 0, 1, TCON_OFF, 32'h1);
    idle(12);
    step(0, 1, 0, TL_OFF, 32'h0);
    push("p4_tl3", K_RD4, 32'd3);
    push("p1_tl12", K_RD1, 32'd12);
    check();
    // PRESCALE=4, IE=0: overflow reloads TL but leaves ST and IRQ low
    step(0, 0, 1, TCON_OFF, 32'h0);
    step(0, 0, 1, TH_OFF, 32'h10);
    step(0, 0, 1, TL_OFF, 32'hFFFF_FFFF);
    step(0, 0, 1, TCON_OFF, 32'h1);
    idle(3);
    step(0, 1, 0, TL_OFF, 32'h0);
    push("p4_tl_ff", K_RD4, 32'hFFFF_FFFF);
    check();
    step(0, 1, 0, TL_OFF, 32'h0);
    push("p4_reload", K_RD4, 32'h10);
    check();
    step(0, 1, 0, TCON_OFF, 32'h0);
    push("p4_st0", K_RD4, 32'h1);
    check();
    step(0, 0, 0, 32'h0, 32'h0);
    push("p4_irq0", K_IRQ4, 32'h0);
    check();

    // Reset with IRQ high on the PRESCALE=1 instance
    step(1, 0, 0, 32'h0, 32'h0);
    step(0, 0, 1, TL_OFF, 32'hFFFF_FFFF);
    step(0, 0, 1, TCON_OFF, 32'h3);
    idle(2);
    step(0, 1, 0, TCON_OFF, 32'h0);
    push("pre_rst_tcon", K_RD1, 32'h7);
    push("pre_rst_irq", K_IRQ1, 32'h1);
    check();
    step(1, 1, 0, TCON_OFF, 32'h0);
    push("rst_gates_rd", K_RD1, 32'h0);
    push("irq_in_rst_cycle", K_IRQ1, 32'h1);
    check();
    step(0, 1, 0, TCON_OFF, 32'h0);
    push("after_rst_tcon", K_RD1, 32'h0);
    push("after_rst_irq", K_IRQ1, 32'h0);
    push("after_rst_tcon4", K_RD4, 32'h0);
    check();
    step(0, 1, 0, TL_OFF, 32'h0);
    push("after_rst_tl", K_RD1, 32'h0);
    push("after_rst_tl4", K_RD4, 32'h0);
    check();
    step(0, 1, 0, SYSTICK_OFF, 32'h0);
    push("after_rst_systick", K_RD1, 32'd2);
    check();

    step(0, 0, 0, 32'h0, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
